mips_multicycle_ctrl: RTL

//  Multicycle MIPS control FSM; the initiator side of the ALU sel interface.

---
 rtl/mips_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM driving ALU select and datapath controls
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic [1:0]       alu_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_zero,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [1:0]       pc_source,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        C_NONE = 4'd0,
        C_LW   = 4'd1,
        C_SW   = 4'd2,
        C_ADD  = 4'd3,
        C_SUB  = 4'd4,
        C_AND  = 4'd5,
        C_OR   = 4'd6,
        C_BEQ  = 4'd7,
        C_J    = 4'd8,
        C_ADDI = 4'd9,
        C_ANDI = 4'd10,
        C_ORI  = 4'd11
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d, cls_dec;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic             pc_write, pc_write_cond, retire;

    // Instruction class from the IR; only consulted while in DECODE.
    always_comb begin
        cls_dec = C_NONE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   cls_dec = C_ADD;
                    6'h22:   cls_dec = C_SUB;
                    6'h24:   cls_dec = C_AND;
                    6'h25:   cls_dec = C_OR;
                    default: cls_dec = C_NONE;
                endcase
            end
            6'h23:   cls_dec = C_LW;
            6'h2B:   cls_dec = C_SW;
            6'h04:   cls_dec = C_BEQ;
            6'h02:   cls_dec = C_J;
            6'h08:   cls_dec = C_ADDI;
            6'h0C:   cls_dec = C_ANDI;
            6'h0D:   cls_dec = C_ORI;
            default: cls_dec = C_NONE;
        endcase
    end

    always_comb begin
        state_d       = S_FETCH;
        cls_d         = cls_q;
        retire        = 1'b0;
        alu_sel       = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ext_zero      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                cls_d     = cls_dec;
                case (cls_dec)
                    C_LW, C_SW:                state_d = S_MEM_ADDR;
                    C_ADD, C_SUB, C_AND, C_OR: state_d = S_R_EXEC;
                    C_BEQ:                     state_d = S_BRANCH;
                    C_J:                       state_d = S_JUMP;
                    C_ADDI, C_ANDI, C_ORI:     state_d = S_I_EXEC;
                    default:                   state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (cls_q == C_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                case (cls_q)
                    C_SUB:   alu_sel = 2'b01;
                    C_AND:   alu_sel = 2'b10;
                    C_OR:    alu_sel = 2'b11;
                    default: alu_sel = 2'b00;
                endcase
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_sel       = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (cls_q)
                    C_ANDI: begin
                        alu_sel  = 2'b10;
                        ext_zero = 1'b1;
                    end
                    C_ORI: begin
                        alu_sel  = 2'b11;
                        ext_zero = 1'b1;
                    end
                    default: alu_sel = 2'b00;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset suppresses every side-effecting strobe in the same cycle.
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign pc_en = ~rst & (pc_write | (pc_write_cond & zero));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
